div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider serving the EX stage of the five-stage MIPS pipeline. EX is the initiator: it raises a start request with operands and a signed/unsigned flag, and holds the pipeline stalled until this block answers. This block answers with a 64-bit result for the HI/LO write path: remainder in the upper word and quotient in the lower word, plus a ready flag. Division is restoring, one quotient bit per cycle, and EX can cancel it mid-flight with an annul input.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (rst == 0 resets immediately, independent of clk).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  32  dividend; sampled with start.
- opdata2_i  input  32  divisor; sampled with start.
- start_i  input  1  request level from EX; held high until ready_o observed, then dropped.
- annul_i  input  1  cancel request; aborts an in-progress division.
- result_o  output  64  {remainder[31:0], quotient[31:0]}; valid while ready_o = 1, else 0.
- ready_o  output  1  result valid; high in END state only.

## Operation
- States: FREE, BYZERO, ON, END. Reset: state = FREE, cnt = 0, result_o = 0, ready_o = 0, internal registers = 0.
- FREE: if start_i = 1 and annul_i = 0:
  - opdata2_i = 0: go to BYZERO.
  - otherwise: go to ON with cnt = 0.
    - Latch the divisor as |opdata2_i| if signed_div_i = 1 and opdata2_i[31] = 1, else as opdata2_i.
    - Latch the dividend magnitude the same way from opdata1_i into working register dividend[64:0] = {32'b0, mag1, 1'b0}.
    - Latch signed_div_i and the operand sign bits for the final fixup.
- FREE with start_i = 0 or annul_i = 1: stay; result_o = 0, ready_o = 0.
- BYZERO: unconditionally go to END; result_o = 64'h0, ready_o = 1. annul_i is ignored in this state.
- ON, annul_i = 1: go to FREE immediately; result_o = 0, ready_o = 0; the partial result is discarded.
- ON, cnt < 32: each cycle is one restoring step on a 33-bit difference.
  - tmp = {1'b0, dividend[63:32]} - {1'b0, divisor}.
  - If tmp[32] = 1 (borrow): dividend <= {dividend[63:0], 1'b0}.
  - Else: dividend <= {tmp[31:0], dividend[31:0], 1'b1}.
  - cnt <= cnt + 1 in both cases.
- ON, cnt = 32: final sign fixup, then go to END.
  - Raw quotient = dividend[31:0]; raw remainder = dividend[64:33].
  - If the divide was signed and the operand signs differ: quotient is two's-complement negated.
  - If the divide was signed and the dividend was negative: remainder is negated (remainder takes the dividend's sign).
  - Drive result_o = {rem, quot} and ready_o = 1; cnt <= 0.
- END, start_i = 1: hold; result_o and ready_o stay stable.
- END, start_i = 0: go to FREE; result_o = 0, ready_o = 0.
- Width and overflow rules: all arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0; no trap.

## Timing
- start_i sampled high at edge T (FREE): ON from T, 32 iteration edges T+1..T+32, fixup at T+33. ready_o = 1 from T+33.
- Divide by zero: BYZERO at T, END with ready_o = 1 from T+1.
- result_o and ready_o are registered; no combinational path from inputs to outputs.
- ready_o stays high while start_i is high. The first edge with start_i low clears ready_o.
- A new request is accepted earliest one edge after leaving END (requires a pass through FREE).
- annul_i sampled high at any edge in ON: FREE at that edge; ready_o never rises for that request.
- rst low at any time, including mid-ON or in END: outputs 0 and state FREE asynchronously. The first request is accepted on the first edge after rst returns high.

## Test plan
- Unsigned 100 / 7: start at T → ready_o rises at T+33, result_o = 64'h00000002_0000000E; drop start → next edge ready_o = 0, result_o = 0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): result_o = 64'hFFFFFFFF_FFFFFFFD. Signed 7 / -2 gives 64'h00000001_FFFFFFFD.
- Divide by zero (5 / 0, signed and unsigned): ready_o at T+1, result_o = 0. Holding start high for 5 cycles keeps ready_o = 1.
- Annul at cycle T+10: state returns to FREE, ready_o stays 0. A fresh 0xFFFFFFFF / 0x10 unsigned request then yields 64'h0000000F_0FFFFFFF.
- Reset mid-division (rst low at T+15 between edges): outputs go 0 without a clock edge. After release, 0x80000000 / 0xFFFFFFFF signed yields 64'h00000000_80000000.
- Back-to-back requests: start held high until ready_o, dropped for one cycle, raised again. The second result is correct and arrives 33 edges after its acceptance.

Source files
------------

// File: rtl/div.sv
// ============================================================================
// Module   : div
// Brief    : Multi-cycle 32-bit restoring divider (signed/unsigned) for EX/HI-LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_CNT = 6'd32;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [64:0] r_dividend, w_dividend_nxt;
    logic [31:0] r_divisor, w_divisor_nxt;
    logic        r_signed, w_signed_nxt;
    logic        r_sign1, w_sign1_nxt;
    logic        r_sign2, w_sign2_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic        r_ready, w_ready_nxt;

    logic [31:0] w_mag1, w_mag2;
    logic [32:0] w_diff;
    logic [31:0] w_quot, w_rem;

    // Operand magnitudes; only negated when the request is signed.
    assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};
    assign w_quot = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_dividend[31:0] + 32'd1)
                                                      : r_dividend[31:0];
    assign w_rem  = (r_signed && r_sign1) ? (~r_dividend[64:33] + 32'd1)
                                          : r_dividend[64:33];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_signed_nxt   = r_signed;
        w_sign1_nxt    = r_sign1;
        w_sign2_nxt    = r_sign2;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            S_FREE: begin
                w_result_nxt = 64'd0;
                w_ready_nxt  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_state_nxt    = S_ON;
                        w_cnt_nxt      = 6'd0;
                        w_divisor_nxt  = w_mag2;
                        w_dividend_nxt = {32'd0, w_mag1, 1'b0};
                        w_signed_nxt   = signed_div_i;
                        w_sign1_nxt    = opdata1_i[31];
                        w_sign2_nxt    = opdata2_i[31];
                    end
                end
            end
            S_BYZERO: begin
                w_state_nxt  = S_END;
                w_result_nxt = 64'd0;
                w_ready_nxt  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_cnt_nxt    = 6'd0;
                    w_result_nxt = 64'd0;
                    w_ready_nxt  = 1'b0;
                end else if (r_cnt != c_LAST_CNT) begin
                    // Restore on borrow: shift only; otherwise keep the difference.
                    if (w_diff[32])
                        w_dividend_nxt = {r_dividend[63:0], 1'b0};
                    else
                        w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_state_nxt  = S_END;
                    w_cnt_nxt    = 6'd0;
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = 1'b1;
                end
            end
            S_END: begin
                if (!start_i) begin
                    w_state_nxt  = S_FREE;
                    w_result_nxt = 64'd0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= 65'd0;
            r_divisor  <= 32'd0;
            r_signed   <= 1'b0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= 64'd0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_signed   <= w_signed_nxt;
            r_sign1    <= w_sign1_nxt;
            r_sign2    <= w_sign2_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
// Module   : tb_div
// Brief    : Directed vector bench for the multi-cycle divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_err = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one request, wait for ready (bounded), check latency and result,
    // then drop start and check outputs clear on the next edge.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int seen;
        seen = 0;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) begin
                seen = n;
                break;
            end
        end
        check({name, " latency"}, 64'(seen), 64'(lat));
        check({name, " result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " clear"}, {result_o, 63'd0, ready_o}, 127'd0);
    endtask

    initial begin
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        vecs[3]  = '{1'b1, 32'd5,          32'd0,          64'h0,                 1};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'h0,                 1};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF, 33};
        vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
        vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
        vecs[10] = '{1'b0, 32'd3,          32'd5,          64'h00000003_00000000, 33};

        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 64'd0);
        check("reset ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Consecutive table entries are back-to-back: one low cycle of start between them.
        for (int i = 0; i < 11; i++)
            run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].lat);

        // Divide by zero with start held: ready must stay up.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd5;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("byzero ready", 64'(ready_o), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("byzero hold%0d", k), {31'd0, ready_o, result_o[31:0]},
                  {31'd0, 1'b1, 32'd0});
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("byzero drop", 64'(ready_o), 64'd0);

        // Annul at T+10: ready must never rise for that request.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        begin
            int hi;
            hi = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (ready_o !== 1'b0) hi++;
            end
            check("annul no ready", 64'(hi), 64'd0);
        end
        run_div("post annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);

        // Reset between edges in mid-division.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("midon rst", {result_o, 63'd0, ready_o}, 127'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            int hi;
            hi = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (ready_o !== 1'b0) hi++;
            end
            check("rst no ready", 64'(hi), 64'd0);
        end
        run_div("post rst", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);

        // Reset while in END with start held: outputs clear without an edge.
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFFF9;
        opdata2_i    = 32'h2;
        start_i      = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        check("end result", result_o, 64'hFFFFFFFF_FFFFFFFD);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("end rst", {result_o, 63'd0, ready_o}, 127'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after end rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
